// File: rtl/spi_master_ctrl.sv
// rtl/spi_master_ctrl.sv - SPI mode-0 master, one 1..MAX_WIDTH-bit transfer per request
module spi_master_ctrl #(
    parameter int MAX_WIDTH = 8,
    parameter int CLK_DIV   = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic [$clog2(MAX_WIDTH+1)-1:0] len,
    input  logic [MAX_WIDTH-1:0]           tx_data,
    output logic                           busy,
    output logic                           done,
    output logic [MAX_WIDTH-1:0]           rx_data,
    output logic                           spi_clk,
    output logic                           spi_mosi,
    input  logic                           spi_miso,
    output logic                           spi_cs
);

    localparam int LW = $clog2(MAX_WIDTH + 1);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_HIGH  = 3'd2;
    localparam logic [2:0] S_LOW   = 3'd3;
    localparam logic [2:0] S_HOLD  = 3'd4;
    localparam logic [2:0] S_GAP   = 3'd5;

    logic [2:0]           state;
    logic [2:0]           state_nxt;
    logic [DW-1:0]        div_cnt;
    logic [LW-1:0]        bit_cnt;
    logic [LW-1:0]        len_q;
    logic [MAX_WIDTH-1:0] tx_sh;
    logic [MAX_WIDTH-1:0] rx_sh;
    logic                 phase_end;
    logic                 accept;
    logic                 nxt_cs_active;

    assign phase_end = (div_cnt == DW'(CLK_DIV - 1));
    assign accept    = (state == S_IDLE) && start && (len != '0) && (len <= LW'(MAX_WIDTH));
    assign busy      = (state != S_IDLE);
    // MOSI is only driven while selected; it parks at 0 in GAP and IDLE.
    assign spi_mosi  = ~spi_cs & tx_sh[MAX_WIDTH-1];

    assign nxt_cs_active = (state_nxt == S_SETUP) || (state_nxt == S_HIGH) ||
                           (state_nxt == S_LOW)   || (state_nxt == S_HOLD);

    // Next-state: every non-idle phase lasts CLK_DIV cycles; the last bit still
    // gets its trailing low half-period before HOLD.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept)    state_nxt = S_SETUP;
            S_SETUP: if (phase_end) state_nxt = S_HIGH;
            S_HIGH:  if (phase_end) state_nxt = S_LOW;
            S_LOW:   if (phase_end) state_nxt = (bit_cnt < len_q) ? S_HIGH : S_HOLD;
            S_HOLD:  if (phase_end) state_nxt = S_GAP;
            S_GAP:   if (phase_end) state_nxt = S_IDLE;
            default:                state_nxt = S_IDLE;
        endcase
    end

    // State register and per-phase divider; divider restarts on every phase change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            div_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE || phase_end) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + DW'(1);
            end
        end
    end

    // Datapath: load at accept, sample MISO at the edge ending HIGH, publish at HOLD end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt <= '0;
            len_q   <= '0;
            tx_sh   <= '0;
            rx_sh   <= '0;
            rx_data <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                len_q   <= len;
                bit_cnt <= '0;
                tx_sh   <= tx_data << (LW'(MAX_WIDTH) - len);
                rx_sh   <= '0;
            end
            if (state == S_HIGH && phase_end) begin
                rx_sh   <= MAX_WIDTH'({rx_sh, spi_miso});
                bit_cnt <= bit_cnt + LW'(1);
                // Keep the last bit on MOSI through HOLD instead of shifting past it.
                if ((bit_cnt + LW'(1)) < len_q) begin
                    tx_sh <= tx_sh << 1;
                end
            end
            if (state == S_HOLD && phase_end) begin
                done    <= 1'b1;
                rx_data <= rx_sh;
            end
        end
    end

    // Registered pin drivers decoded from the next state, so spi_clk/spi_cs are glitch-free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spi_cs  <= 1'b1;
            spi_clk <= 1'b0;
        end else begin
            spi_cs  <= ~nxt_cs_active;
            spi_clk <= (state_nxt == S_HIGH);
        end
    end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb/tb_spi_master_ctrl.sv - scoreboard bench for spi_master_ctrl with slave BFMs
module tb_spi_master_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]  start = '0;
    logic [3:0]  len0 = '0;
    logic [4:0]  len1 = '0;
    logic [3:0]  len2 = '0;
    logic [7:0]  tx0 = '0;
    logic [15:0] tx1 = '0;
    logic [7:0]  tx2 = '0;
    wire  [7:0]  rx0;
    wire  [15:0] rx1;
    wire  [7:0]  rx2;
    wire  [2:0]  busy, done, sclk, mosi, miso, cs;
    wire  [15:0] rx_all [3];
    wire  [15:0] slv_rcv [3];
    wire  [7:0]  slv_edges [3];
    logic [15:0] ret_val [3] = '{16'h0, 16'h0, 16'h0};
    logic [4:0]  ret_len [3] = '{5'd8, 5'd8, 5'd8};
    int          dval [3] = '{4, 4, 1};

    assign rx_all[0] = {8'h00, rx0};
    assign rx_all[1] = rx1;
    assign rx_all[2] = {8'h00, rx2};

    spi_master_ctrl #(.MAX_WIDTH(8), .CLK_DIV(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .len(len0), .tx_data(tx0),
        .busy(busy[0]), .done(done[0]), .rx_data(rx0), .spi_clk(sclk[0]),
        .spi_mosi(mosi[0]), .spi_miso(miso[0]), .spi_cs(cs[0]));

    spi_master_ctrl #(.MAX_WIDTH(16), .CLK_DIV(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .len(len1), .tx_data(tx1),
        .busy(busy[1]), .done(done[1]), .rx_data(rx1), .spi_clk(sclk[1]),
        .spi_mosi(mosi[1]), .spi_miso(miso[1]), .spi_cs(cs[1]));

    spi_master_ctrl #(.MAX_WIDTH(8), .CLK_DIV(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start[2]), .len(len2), .tx_data(tx2),
        .busy(busy[2]), .done(done[2]), .rx_data(rx2), .spi_clk(sclk[2]),
        .spi_mosi(mosi[2]), .spi_miso(miso[2]), .spi_cs(cs[2]));

    // Mode-0 slave: first bit on CS fall, capture on rising, shift out on falling.
    for (genvar g = 0; g < 3; g++) begin : g_bfm
        logic [15:0] sh = '0;
        logic [15:0] rcv = '0;
        logic [7:0]  edges = '0;
        always @(negedge cs[g]) begin
            sh    <= ret_val[g] << (5'd16 - ret_len[g]);
            rcv   <= '0;
            edges <= '0;
        end
        always @(posedge sclk[g]) begin
            rcv   <= {rcv[14:0], mosi[g]};
            edges <= edges + 8'd1;
        end
        always @(negedge sclk[g]) sh <= sh << 1;
        assign miso[g]      = sh[15];
        assign slv_rcv[g]   = rcv;
        assign slv_edges[g] = edges;
    end

    typedef struct {
        int          inst;
        logic [15:0] rx;
        logic [15:0] tx;
        int          len;
    } exp_t;
    exp_t q[$];

    int errors = 0;
    int checks = 0;
    int viol   = 0;
    bit mon_en = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every done and tracks pin timing.
    initial begin
        int cs_run [3] = '{0, 0, 0};
        int hi_run [3] = '{0, 0, 0};
        int last_low [3] = '{0, 0, 0};
        int busy_run [3] = '{0, 0, 0};
        int exp_busy [3] = '{0, 0, 0};
        bit seen_low [3] = '{0, 0, 0};
        logic [2:0] done_prev = '0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                for (int i = 0; i < 3; i++) begin
                    if (!cs[i]) begin
                        if (cs_run[i] == 0 && seen_low[i]) begin
                            checks++;
                            if (hi_run[i] < dval[i]) begin
                                errors++;
                                $display("FAIL cs_gap inst%0d: got %0d expected >= %0d", i, hi_run[i], dval[i]);
                            end
                        end
                        hi_run[i] = 0;
                        seen_low[i] = 1'b1;
                        cs_run[i]++;
                    end else begin
                        hi_run[i]++;
                        if (cs_run[i] != 0) begin
                            last_low[i] = cs_run[i];
                            cs_run[i] = 0;
                        end
                    end
                    if (cs[i] && (sclk[i] || mosi[i])) viol++;
                    if (done[i] && done_prev[i]) viol++;
                    if (busy[i]) begin
                        busy_run[i]++;
                    end else begin
                        if (busy_run[i] != 0 && exp_busy[i] != 0) chk("busy_len", busy_run[i], exp_busy[i]);
                        busy_run[i] = 0;
                        exp_busy[i] = 0;
                    end
                    if (done[i]) begin
                        if (q.size() == 0 || q[0].inst != i) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_done inst%0d: got done expected none", i);
                        end else begin
                            e = q.pop_front();
                            chk("rx_data", int'(rx_all[i]), int'(e.rx));
                            chk("slave_rx", int'(slv_rcv[i]), int'(e.tx));
                            chk("clk_edges", int'(slv_edges[i]), e.len);
                            chk("cs_low_len", last_low[i], dval[i] * (2 * e.len + 2));
                            exp_busy[i] = dval[i] * (2 * e.len + 3);
                        end
                    end
                end
                done_prev = done;
            end
        end
    end

    task automatic set_req(input int i, input int n, input logic [15:0] tx);
        case (i)
            0: begin len0 = 4'(n); tx0 = tx[7:0]; end
            1: begin len1 = 5'(n); tx1 = tx; end
            default: begin len2 = 4'(n); tx2 = tx[7:0]; end
        endcase
    endtask

    task automatic wait_idle(input int i);
        int t = 0;
        while (busy[i] && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 1000) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout inst%0d: got busy expected idle", i);
        end
    endtask

    task automatic go(input int i, input int n, input logic [15:0] tx, input logic [15:0] ret);
        exp_t e;
        ret_val[i] = ret;
        ret_len[i] = 5'(n);
        e.inst = i; e.rx = ret; e.tx = tx; e.len = n;
        q.push_back(e);
        set_req(i, n, tx);
        start[i] = 1'b1;
        @(negedge clk);
        start[i] = 1'b0;
        wait_idle(i);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int bad;
        exp_t e;
        repeat (3) @(negedge clk);
        chk("rst_cs", int'(cs), 7);
        chk("rst_sclk", int'(sclk), 0);
        chk("rst_mosi", int'(mosi), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_rx", int'(rx0) + int'(rx1) + int'(rx2), 0);
        rst_n = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);

        go(0, 8, 16'h00A5, 16'h003C);
        go(1, 12, 16'h0ABC, 16'h05F1);
        go(2, 1, 16'h0001, 16'h0001);

        // Held start: transfers accepted at edges 0, 77 and 154 only.
        ret_val[0] = 16'h00C3;
        ret_len[0] = 5'd8;
        e.inst = 0; e.rx = 16'h00C3; e.tx = 16'h0081; e.len = 8;
        repeat (3) q.push_back(e);
        set_req(0, 8, 16'h0081);
        start[0] = 1'b1;
        repeat (200) @(negedge clk);
        start[0] = 1'b0;
        wait_idle(0);

        // Reset during bit 4 of an 8'hFF transfer.
        ret_val[0] = 16'h0000;
        set_req(0, 8, 16'h00FF);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (29) @(negedge clk);
        chk("pre_rst_sclk", int'(sclk[0]), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_cs", int'(cs[0]), 1);
        chk("abort_sclk", int'(sclk[0]), 0);
        chk("abort_busy", int'(busy[0]), 0);
        chk("abort_mosi", int'(mosi[0]), 0);
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        go(0, 8, 16'h0055, 16'h0099);

        // Out-of-range lengths are ignored.
        set_req(0, 0, 16'h00FF);
        start[0] = 1'b1;
        @(negedge clk);
        set_req(0, 9, 16'h00FF);
        @(negedge clk);
        start[0] = 1'b0;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (busy[0] || !cs[0]) bad++;
        end
        chk("bad_len_ignored", bad, 0);

        repeat (10) @(negedge clk);
        chk("scoreboard_empty", q.size(), 0);
        chk("pin_invariants", viol, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
